// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, FSM states and
// a small decode helper used by both the unit and its neighbours.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // True for ops that occupy the unit for several cycles (stall decode uses this too).
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_divider.sv
// Combinational signed/unsigned divider producing quotient and remainder,
// including the divide-by-zero and most-negative / -1 corner cases.
module md_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;

  assign a_s = $signed(a);
  assign b_s = $signed(b);

  // Signed '/' truncates toward zero and '%' follows the dividend's sign.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (b == '0) begin
      quot = '1;
      rem  = a;
    end else if (is_signed && (a == MOST_NEG) && (b == '1)) begin
      quot = a;
      rem  = '0;
    end else if (is_signed) begin
      quot = $unsigned(a_s / b_s);
      rem  = $unsigned(a_s % b_s);
    end else begin
      quot = a / b;
      rem  = a % b;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at accept time and held in pending registers until the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;

  logic signed [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
  logic        [2*WIDTH-1:0] a_ext_u, b_ext_u, prod_u;
  logic        [WIDTH-1:0]   div_quot, div_rem;

  // Operands are widened explicitly so the low 2*WIDTH bits hold the full product.
  assign a_ext_s = $signed({{WIDTH{a[WIDTH-1]}}, a});
  assign b_ext_s = $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_s  = a_ext_s * b_ext_s;
  assign a_ext_u = {{WIDTH{1'b0}}, a};
  assign b_ext_u = {{WIDTH{1'b0}}, b};
  assign prod_u  = a_ext_u * b_ext_u;

  md_divider #(.WIDTH(WIDTH)) u_divider (
    .a         (a),
    .b         (b),
    .is_signed (op == MD_DIV),
    .quot      (div_quot),
    .rem       (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      MD_IDLE: begin
        if (start && !cancel) begin
          case (op)
            MD_MULT: begin
              {pend_hi_d, pend_lo_d} = $unsigned(prod_s);
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = MD_BUSY;
            end
            MD_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d   = CNT_W'(MUL_CYCLES);
              state_d = MD_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              pend_hi_d = div_rem;
              pend_lo_d = div_quot;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = MD_BUSY;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        // Cancel beats the commit so an aborted op never reaches HI/LO.
        if (cancel) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Pending results are pure data and only matter while BUSY.
  always_ff @(posedge clk) begin
    pend_hi_q <= pend_hi_d;
    pend_lo_q <= pend_lo_d;
  end

  assign busy = (state_q == MD_BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus randomized ops checked
// against an arithmetic reference model of HI/LO and the op latencies.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W     = 32;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] hi_m, lo_m;

  mult_div_unit #(.WIDTH(W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: returns {hi, lo} from plain arithmetic on the operand values.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] av,
                                             input logic [31:0] bv,
                                             input logic [31:0] h, input logic [31:0] l);
    longint sa, sb, q, r, mag;
    longint unsigned ua, ub;
    sa = $signed(av);
    sb = $signed(bv);
    ua = av;
    ub = bv;
    case (o)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV, MD_DIVU: begin
        if (bv == 0) return {av, 32'hFFFF_FFFF};
        if (o == MD_DIVU) return {32'(ua % ub), 32'(ua / ub)};
        mag = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        q   = ((sa < 0) != (sb < 0)) ? -mag : mag;
        r   = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      MD_MTHI:  return {av, l};
      MD_MTLO:  return {h, av};
      default:  return {h, l};
    endcase
  endfunction

  // Issue a multi-cycle op; optionally at busy cycle 'intr' either cancel or try a second start.
  task automatic run_long(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input int intr, input logic intr_cancel);
    logic [63:0] exp;
    int n, need;
    logic cancelled;
    need      = (o == MD_MULT || o == MD_MULTU) ? MUL_N : DIV_N;
    cancelled = intr_cancel && intr >= 1 && intr <= need;
    exp       = cancelled ? {hi_m, lo_m} : ref_result(o, av, bv, hi_m, lo_m);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      if (n + 1 == intr) begin
        if (intr_cancel) cancel = 1'b1;
        else begin
          start = 1'b1; op = MD_MTHI; a = 32'hDEAD_BEEF;
        end
      end
      n++;
      tick();
      start = 1'b0; cancel = 1'b0;
    end
    check({tag, " busy_cycles"}, 64'(n), cancelled ? 64'(intr) : 64'(need));
    check({tag, " done"}, {63'd0, done}, cancelled ? 64'd0 : 64'd1);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp[63:32]});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp[31:0]});
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    tick();
    check({tag, " done_drop"}, {63'd0, done}, 64'd0);
  endtask

  task automatic run_short(input string tag, input logic [2:0] o, input logic [31:0] av,
                           input logic cncl);
    logic [63:0] exp;
    exp = cncl ? {hi_m, lo_m} : ref_result(o, av, 32'd0, hi_m, lo_m);
    start = 1'b1; op = o; a = av; cancel = cncl;
    tick();
    start = 1'b0; cancel = 1'b0;
    check({tag, " busy"}, {63'd0, busy}, 64'd0);
    check({tag, " hilo"}, {hi, lo}, exp);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = MD_MULT; a = '0; b = '0; cancel = 1'b0;
    hi_m = '0; lo_m = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset busy_done", {62'd0, busy, done}, 64'd0);

    run_long("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, -1, 1'b0);
    check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_long("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, 1'b0);
    check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_long("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
    check("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_long("divu_zero", MD_DIVU, 32'd7, 32'd0, -1, 1'b0);
    check("divu_zero const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_long("div_zero", MD_DIV, 32'hFFFF_FF00, 32'd0, -1, 1'b0);
    run_long("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
    check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

    run_short("mthi", MD_MTHI, 32'h1234, 1'b0);
    run_short("mtlo", MD_MTLO, 32'h5678, 1'b0);
    check("mthi_mtlo const", {hi, lo}, 64'h0000_1234_0000_5678);

    run_long("div_start_busy", MD_DIV, 32'd100, 32'd7, 3, 1'b0);
    run_long("div_cancel", MD_DIV, 32'd55, 32'd3, 4, 1'b1);
    run_long("mult_cancel_commit", MD_MULT, 32'd9, 32'd9, MUL_N, 1'b1);

    run_short("idle_cancel_mthi", MD_MTHI, 32'hAAAA_5555, 1'b1);
    start = 1'b1; op = MD_DIVU; a = 32'd10; b = 32'd3; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_div busy", {63'd0, busy}, 64'd0);
    start = 1'b1; op = 3'd6; a = 32'd10; b = 32'd3;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("bad_op busy", {63'd0, busy}, 64'd0);
    check("bad_op hilo", {hi, lo}, {hi_m, lo_m});

    // Reset in the middle of a multiply must discard it entirely.
    start = 1'b1; op = MD_MULT; a = 32'd1000; b = 32'd1000;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hi_m = '0; lo_m = '0;
    check("reset_mid hilo", {hi, lo}, 64'd0);
    check("reset_mid busy", {63'd0, busy}, 64'd0);
    for (int i = 0; i < MUL_N + 2; i++) begin
      tick();
      check("reset_mid no_commit", {63'd0, done, hi, lo}, 64'd0);
    end

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (ro == MD_DIV && $urandom_range(0, 4) == 0) begin
        ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      if (md_is_long(ro)) run_long("rand_long", ro, ra, rb, -1, 1'b0);
      else run_short("rand_short", ro, ra, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
